// File: rtl/sim_test_ctrl.sv
// Memory-mapped test-control responder: tohost pass/fail, console byte FIFO and watchdog.
// Optional SIM_TEST_CTRL_PRINT_EN adds simulation-only console echo and end-of-test messages.
module sim_test_ctrl #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WDOG_CYCLES = 100000,
  parameter int unsigned CON_DEPTH   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              test_done,
  output logic              test_pass,
  output logic [30:0]       test_code,
  output logic              timeout,
  output logic              con_valid,
  output logic [7:0]        con_data,
  input  logic              con_ready
);

  localparam int unsigned PTR_W = (CON_DEPTH > 1) ? $clog2(CON_DEPTH) : 1;

  localparam logic [ADDR_W-1:0] OFF_TOHOST  = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] OFF_CONSOLE = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] OFF_CYC_LO  = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] OFF_CYC_HI  = ADDR_W'(8'h0C);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DONE    = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_t;

  state_t            state;
  logic [63:0]       cycle_cnt;
  logic [31:0]       cyc_hi_shadow;

  logic [7:0]        fifo_mem [CON_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    fifo_cnt;
  logic              fifo_empty;
  logic              fifo_full;

  logic              sel_tohost;
  logic              sel_console;
  logic              sel_cyc_lo;
  logic              sel_cyc_hi;
  logic              accept;
  logic              push;
  logic              pop;
  logic [31:0]       wmask;
  logic [31:0]       tohost_val;
  logic              tohost_wr;
  logic              wdog_hit;
  logic [31:0]       read_data;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^req_addr[1:0];

  assign sel_tohost  = (req_addr[ADDR_W-1:2] == OFF_TOHOST[ADDR_W-1:2]);
  assign sel_console = (req_addr[ADDR_W-1:2] == OFF_CONSOLE[ADDR_W-1:2]);
  assign sel_cyc_lo  = (req_addr[ADDR_W-1:2] == OFF_CYC_LO[ADDR_W-1:2]);
  assign sel_cyc_hi  = (req_addr[ADDR_W-1:2] == OFF_CYC_HI[ADDR_W-1:2]);

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == (PTR_W+1)'(CON_DEPTH));

  // Only a console write into a full FIFO stalls; everything else is accepted immediately.
  assign req_ready = ~(req_we & sel_console & fifo_full);
  assign accept    = req_valid & req_ready;
  assign push      = accept & req_we & sel_console & req_wstrb[0];
  assign pop       = con_valid & con_ready;

  assign con_valid = ~fifo_empty;
  assign con_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];

  assign wmask      = {{8{req_wstrb[3]}}, {8{req_wstrb[2]}}, {8{req_wstrb[1]}}, {8{req_wstrb[0]}}};
  assign tohost_val = req_wdata & wmask;
  assign tohost_wr  = accept & req_we & sel_tohost & tohost_val[0];
  assign wdog_hit   = (WDOG_CYCLES != 0) && (cycle_cnt == 64'(WDOG_CYCLES));

  always_comb begin
    read_data = '0;
    if (!req_we) begin
      if (sel_tohost)       read_data = {test_code, test_done};
      else if (sel_console) read_data = {30'b0, fifo_full, fifo_empty};
      else if (sel_cyc_lo)  read_data = cycle_cnt[31:0];
      else if (sel_cyc_hi)  read_data = cyc_hi_shadow;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_RUN;
      test_done     <= 1'b0;
      test_pass     <= 1'b0;
      test_code     <= '0;
      timeout       <= 1'b0;
      cycle_cnt     <= '0;
      cyc_hi_shadow <= '0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      rsp_valid <= accept;
      rsp_rdata <= accept ? read_data : '0;
      // LO read snapshots the upper half so a following HI read is coherent.
      if (accept && !req_we && sel_cyc_lo)
        cyc_hi_shadow <= cycle_cnt[63:32];
      case (state)
        ST_RUN: begin
          if (tohost_wr) begin
            state     <= ST_DONE;
            test_done <= 1'b1;
            test_code <= tohost_val[31:1];
            test_pass <= (tohost_val[31:1] == '0);
          end else if (wdog_hit) begin
            state   <= ST_TIMEOUT;
            timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= req_wdata[7:0];
  end

`ifdef SIM_TEST_CTRL_PRINT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push) $write("%c", req_wdata[7:0]);
      if (state == ST_RUN && tohost_wr) begin
        if (tohost_val[31:1] == '0)
          $display("TEST PASS at cycle %0d", cycle_cnt);
        else
          $display("TEST FAIL code=%0d at cycle %0d", tohost_val[31:1], cycle_cnt);
      end else if (state == ST_RUN && wdog_hit) begin
        $display("TEST TIMEOUT at cycle %0d", cycle_cnt);
      end
    end
  end
`else
`endif

endmodule
